// File: rtl/adc_axis_packer_pkg.sv
// Shared definitions for the ADC-to-AXI-Stream packer and the ADC channel front-ends.
package adc_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    GATHER = 2'd2,
    SEND   = 2'd3
  } state_t;

  function automatic int calc_beats(input int num_ch, input int ch_per_beat);
    return num_ch / ch_per_beat;
  endfunction

  // Index widths never collapse to zero bits, even for a range of one.
  function automatic int calc_idx_w(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/adc_axis_packer_if.sv
// AXI4-Stream beat bus between the packer (master) and the DMA S2MM input (slave).
interface adc_axis_packer_if #(
  parameter int TDATA_W = 128
);
  // A beat transfers on a rising edge where tvalid && tready; once tvalid is high,
  // tdata/tlast stay stable and tvalid stays high until that transfer happens.
  logic [TDATA_W-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_axis_packer_group_sel.sv
// Combinational selection of one channel group's data slice and its all-flags-ready bit.
module adc_group_sel
  import adc_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CH_PER_BEAT = 4,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_CH*DATA_W-1:0]      data_in,
  input  logic [NUM_CH-1:0]             flag_in,
  input  logic [IDX_W-1:0]              idx,
  output logic [CH_PER_BEAT*DATA_W-1:0] grp_data,
  output logic                          grp_ready
);

  localparam int BEATS  = calc_beats(NUM_CH, CH_PER_BEAT);
  localparam int BEAT_W = CH_PER_BEAT * DATA_W;

  always_comb begin
    grp_data  = '0;
    grp_ready = 1'b0;
    for (int g = 0; g < BEATS; g++) begin
      if (idx == IDX_W'(g)) begin
        grp_data  = data_in[g*BEAT_W +: BEAT_W];
        grp_ready = &flag_in[g*CH_PER_BEAT +: CH_PER_BEAT];
      end
    end
  end

endmodule

// File: rtl/adc_axis_packer.sv
// Packs NUM_CH flag-gated ADC channel words into CH_PER_BEAT-word AXI-Stream beats,
// with tlast on the final beat of every FRAMES_PER_PKT-frame packet.
module adc_axis_packer
  import adc_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int CH_PER_BEAT    = 4,
  parameter int FRAMES_PER_PKT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     cont_mode,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        flag_in,
  output logic [NUM_CH-1:0]        flag_out,
  output logic                     busy,
  output state_t                   fsm_state,
  adc_axis_packer_if.master        m_axis
);

  localparam int BEATS  = calc_beats(NUM_CH, CH_PER_BEAT);
  localparam int BEAT_W = CH_PER_BEAT * DATA_W;
  localparam int BIW    = calc_idx_w(BEATS);
  localparam int FIW    = calc_idx_w(FRAMES_PER_PKT);
  localparam logic [BIW-1:0] LAST_BEAT  = BIW'(BEATS - 1);
  localparam logic [FIW-1:0] LAST_FRAME = FIW'(FRAMES_PER_PKT - 1);

  state_t              state, state_nxt;
  logic [BIW-1:0]      beat_idx, beat_nxt, next_idx;
  logic [FIW-1:0]      frame_idx, frame_nxt;
  logic                mode_r, mode_nxt;
  logic [NUM_CH-1:0]   flag_r, flag_nxt;
  logic [BEAT_W-1:0]   tdata_r, tdata_nxt;
  logic                tvalid_r, tvalid_nxt;
  logic                tlast_r, tlast_nxt;
  logic [BEAT_W-1:0]   cur_data, nxt_data;
  logic                cur_ready, nxt_ready;

  function automatic logic [NUM_CH-1:0] group_mask(input logic [BIW-1:0] idx);
    logic [NUM_CH-1:0] m;
    m = '0;
    for (int g = 0; g < BEATS; g++) begin
      if (idx == BIW'(g)) m[g*CH_PER_BEAT +: CH_PER_BEAT] = '1;
    end
    return m;
  endfunction

  // The second selector looks one group ahead so a ready group can follow a
  // handshake on the very next cycle without a bubble.
  assign next_idx = (beat_idx == LAST_BEAT) ? '0 : beat_idx + BIW'(1);

  adc_group_sel #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_PER_BEAT(CH_PER_BEAT), .IDX_W(BIW)
  ) u_sel_cur (
    .data_in(data_in), .flag_in(flag_in), .idx(beat_idx),
    .grp_data(cur_data), .grp_ready(cur_ready)
  );

  adc_group_sel #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_PER_BEAT(CH_PER_BEAT), .IDX_W(BIW)
  ) u_sel_nxt (
    .data_in(data_in), .flag_in(flag_in), .idx(next_idx),
    .grp_data(nxt_data), .grp_ready(nxt_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_idx  <= '0;
      frame_idx <= '0;
      mode_r    <= 1'b0;
      flag_r    <= '0;
      tdata_r   <= '0;
      tvalid_r  <= 1'b0;
      tlast_r   <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_idx  <= beat_nxt;
      frame_idx <= frame_nxt;
      mode_r    <= mode_nxt;
      flag_r    <= flag_nxt;
      tdata_r   <= tdata_nxt;
      tvalid_r  <= tvalid_nxt;
      tlast_r   <= tlast_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat_idx;
    frame_nxt  = frame_idx;
    mode_nxt   = mode_r;
    flag_nxt   = flag_r;
    tdata_nxt  = tdata_r;
    tvalid_nxt = tvalid_r;
    tlast_nxt  = tlast_r;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ARM;
          mode_nxt  = cont_mode;
          beat_nxt  = '0;
          frame_nxt = '0;
        end
      end
      ARM: begin
        flag_nxt  = '1;
        state_nxt = GATHER;
      end
      GATHER: begin
        if (cur_ready) begin
          tdata_nxt  = cur_data;
          tvalid_nxt = 1'b1;
          tlast_nxt  = (beat_idx == LAST_BEAT) && (frame_idx == LAST_FRAME);
          flag_nxt   = flag_r & ~group_mask(beat_idx);
          state_nxt  = SEND;
        end
      end
      SEND: begin
        if (tvalid_r && m_axis.tready) begin
          if (beat_idx != LAST_BEAT) begin
            beat_nxt = next_idx;
            if (nxt_ready) begin
              tdata_nxt  = nxt_data;
              tvalid_nxt = 1'b1;
              tlast_nxt  = (next_idx == LAST_BEAT) && (frame_idx == LAST_FRAME);
              flag_nxt   = flag_r & ~group_mask(next_idx);
            end else begin
              tvalid_nxt = 1'b0;
              state_nxt  = GATHER;
            end
          end else if (frame_idx != LAST_FRAME) begin
            beat_nxt   = '0;
            frame_nxt  = frame_idx + FIW'(1);
            tvalid_nxt = 1'b0;
            state_nxt  = ARM;
          end else begin
            // Packet boundary: the only point where stop is honoured.
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
            beat_nxt   = '0;
            frame_nxt  = '0;
            state_nxt  = (mode_r && !stop) ? ARM : IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m_axis.tdata  = tdata_r;
  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tlast  = tlast_r;
  assign flag_out      = flag_r;
  assign busy          = (state != IDLE);
  assign fsm_state     = state;

endmodule

// File: tb/tb_adc_axis_packer.sv
// Directed bench for adc_axis_packer: default build, a 3-frame packet build and a 16-channel build.
module tb_adc_axis_packer;
  import adc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Default build: 8 ch x 32 b, 4 per beat, 1 frame per packet
  logic a_start = 0, a_stop = 0, a_cont = 0;
  logic [255:0] a_data = '0;
  logic [7:0]   a_flag_in = '0, a_flag_out;
  logic         a_busy;
  state_t       a_state;
  logic [31:0]  a_word[8];
  adc_axis_packer_if #(.TDATA_W(128)) a_if();
  adc_axis_packer dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop), .cont_mode(a_cont),
    .data_in(a_data), .flag_in(a_flag_in), .flag_out(a_flag_out), .busy(a_busy),
    .fsm_state(a_state), .m_axis(a_if.master)
  );

  // Three frames per packet
  logic b_start = 0, b_stop = 0, b_cont = 0;
  logic [255:0] b_data = '0;
  logic [7:0]   b_flag_in = '0, b_flag_out;
  logic         b_busy;
  state_t       b_state;
  logic [31:0]  b_word[8];
  adc_axis_packer_if #(.TDATA_W(128)) b_if();
  adc_axis_packer #(.FRAMES_PER_PKT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .cont_mode(b_cont),
    .data_in(b_data), .flag_in(b_flag_in), .flag_out(b_flag_out), .busy(b_busy),
    .fsm_state(b_state), .m_axis(b_if.master)
  );

  // 16 ch x 16 b, 2 per beat
  logic c_start = 0, c_stop = 0, c_cont = 0;
  logic [255:0] c_data = '0;
  logic [15:0]  c_flag_in = '0, c_flag_out;
  logic         c_busy;
  state_t       c_state;
  logic [15:0]  c_word[16];
  adc_axis_packer_if #(.TDATA_W(32)) c_if();
  adc_axis_packer #(.NUM_CH(16), .DATA_W(16), .CH_PER_BEAT(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .stop(c_stop), .cont_mode(c_cont),
    .data_in(c_data), .flag_in(c_flag_in), .flag_out(c_flag_out), .busy(c_busy),
    .fsm_state(c_state), .m_axis(c_if.master)
  );

  logic [128:0] got_a[$], got_b[$];
  logic [32:0]  got_c[$];
  logic [128:0] exp_q[$], exp_qb[$];
  logic [32:0]  exp_qc[$];

  // Inputs change at posedge+1, so a handshake seen at negedge is the one taken next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_if.tvalid && a_if.tready) got_a.push_back({a_if.tlast, a_if.tdata});
      if (b_if.tvalid && b_if.tready) got_b.push_back({b_if.tlast, b_if.tdata});
      if (c_if.tvalid && c_if.tready) got_c.push_back({c_if.tlast, c_if.tdata});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a_words(input logic [31:0] base);
    for (int k = 0; k < 8; k++) begin
      a_word[k] = base + 32'(k + 1);
      a_data[k*32 +: 32] = a_word[k];
    end
    exp_q.delete();
    got_a.delete();
    exp_q.push_back({1'b0, a_word[3], a_word[2], a_word[1], a_word[0]});
    exp_q.push_back({1'b1, a_word[7], a_word[6], a_word[5], a_word[4]});
  endtask

  task automatic wait_a_idle;
    int n = 0;
    while (a_busy && n < 50) begin tick(); n++; end
    checks++; if (a_busy !== 1'b0) $display("FAIL a_idle_timeout: busy=%b want 0", a_busy); else passes++;
  endtask

  task automatic compare_a(input string tag);
    checks++;
    if (got_a.size() != exp_q.size()) $display("FAIL %s_count: got %0d beats want %0d", tag, got_a.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_q[i]) $display("FAIL %s_beat%0d: got %h want %h", tag, i, got_a[i], exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_reset;
    a_if.tready = 1'b0; b_if.tready = 1'b0; c_if.tready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (a_if.tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", a_if.tvalid); else passes++;
    checks++; if (a_if.tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", a_if.tlast); else passes++;
    checks++; if (a_if.tdata !== 128'h0) $display("FAIL rst_tdata: got %h want 0", a_if.tdata); else passes++;
    checks++; if (a_flag_out !== 8'h00) $display("FAIL rst_flag_out: got %h want 00", a_flag_out); else passes++;
    checks++; if (a_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", a_busy); else passes++;
    checks++; if (a_state !== IDLE) $display("FAIL rst_state: got %0d want IDLE", a_state); else passes++;
    checks++; if (b_if.tvalid !== 1'b0 || c_if.tvalid !== 1'b0) $display("FAIL rst_other_tvalid: got %b%b want 00", b_if.tvalid, c_if.tvalid); else passes++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    set_a_words(32'hA000_0000);
    a_if.tready = 1'b1; a_cont = 1'b0; a_flag_in = 8'h00; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++; if (a_busy !== 1'b1) $display("FAIL basic_busy_arm: got %b want 1", a_busy); else passes++;
    tick();
    checks++; if (a_flag_out !== 8'hFF) $display("FAIL basic_flag_arm: got %h want ff", a_flag_out); else passes++;
    a_flag_in = 8'h0F;
    tick();
    checks++; if (a_if.tvalid !== 1'b1) $display("FAIL basic_tvalid_b0: got %b want 1", a_if.tvalid); else passes++;
    checks++; if (a_flag_out !== 8'hF0) $display("FAIL basic_flag_b0: got %h want f0", a_flag_out); else passes++;
    checks++; if (a_if.tlast !== 1'b0) $display("FAIL basic_tlast_b0: got %b want 0", a_if.tlast); else passes++;
    tick();
    checks++; if (a_if.tvalid !== 1'b0) $display("FAIL basic_bubble: got %b want 0", a_if.tvalid); else passes++;
    tick();
    a_flag_in = 8'hFF;
    tick();
    checks++; if (a_if.tvalid !== 1'b1 || a_if.tlast !== 1'b1) $display("FAIL basic_b1_last: got v=%b l=%b want 1 1", a_if.tvalid, a_if.tlast); else passes++;
    checks++; if (a_flag_out !== 8'h00) $display("FAIL basic_flag_b1: got %h want 00", a_flag_out); else passes++;
    tick();
    checks++; if (a_busy !== 1'b0 || a_state !== IDLE) $display("FAIL basic_end_idle: got busy=%b state=%0d want 0 IDLE", a_busy, a_state); else passes++;
    checks++; if (a_if.tvalid !== 1'b0 || a_if.tlast !== 1'b0) $display("FAIL basic_end_out: got v=%b l=%b want 0 0", a_if.tvalid, a_if.tlast); else passes++;
    compare_a("basic");
    a_flag_in = 8'h00;
  endtask

  task automatic test_backpressure;
    logic [128:0] snap;
    int n = 0;
    set_a_words(32'hB000_0000);
    a_if.tready = 1'b0; a_flag_in = 8'hFF; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    while (!a_if.tvalid && n < 20) begin tick(); n++; end
    checks++; if (a_if.tvalid !== 1'b1) $display("FAIL bp_tvalid_timeout: got %b want 1", a_if.tvalid); else passes++;
    snap = {a_if.tlast, a_if.tdata};
    repeat (5) begin
      tick();
      checks++;
      if ({a_if.tvalid, a_if.tlast, a_if.tdata} !== {1'b1, snap})
        $display("FAIL bp_hold: got v=%b %h want 1 %h", a_if.tvalid, {a_if.tlast, a_if.tdata}, snap);
      else passes++;
    end
    a_if.tready = 1'b1;
    wait_a_idle();
    compare_a("bp");
    a_flag_in = 8'h00;
  endtask

  task automatic test_back_to_back;
    int n = 0;
    set_a_words(32'hC000_0000);
    a_if.tready = 1'b1; a_flag_in = 8'hFF; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    while (!a_if.tvalid && n < 20) begin tick(); n++; end
    checks++; if ({a_if.tvalid, a_if.tlast, a_if.tdata} !== {1'b1, exp_q[0]}) $display("FAIL b2b_first: got v=%b %h want 1 %h", a_if.tvalid, {a_if.tlast, a_if.tdata}, exp_q[0]); else passes++;
    tick();
    checks++; if ({a_if.tvalid, a_if.tlast, a_if.tdata} !== {1'b1, exp_q[1]}) $display("FAIL b2b_second: got v=%b %h want 1 %h", a_if.tvalid, {a_if.tlast, a_if.tdata}, exp_q[1]); else passes++;
    tick();
    checks++; if (a_if.tvalid !== 1'b0) $display("FAIL b2b_after: got %b want 0", a_if.tvalid); else passes++;
    wait_a_idle();
    compare_a("b2b");
    a_flag_in = 8'h00;
  endtask

  task automatic test_stop_packet;
    int n = 0;
    for (int k = 0; k < 8; k++) begin
      b_word[k] = 32'hD000_0000 + 32'(k + 1);
      b_data[k*32 +: 32] = b_word[k];
    end
    exp_qb.delete(); got_b.delete();
    for (int p = 0; p < 2; p++)
      for (int f = 0; f < 3; f++) begin
        exp_qb.push_back({1'b0, b_word[3], b_word[2], b_word[1], b_word[0]});
        exp_qb.push_back({(f == 2), b_word[7], b_word[6], b_word[5], b_word[4]});
      end
    b_flag_in = 8'hFF; b_cont = 1'b1; b_stop = 1'b0; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    do begin
      b_if.tready = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (got_b.size() >= 8) b_stop = 1'b1;
    end while (b_busy && n < 400);
    checks++; if (b_busy !== 1'b0) $display("FAIL stop_idle_timeout: busy=%b want 0", b_busy); else passes++;
    b_if.tready = 1'b1;
    repeat (10) tick();
    checks++; if (b_state !== IDLE) $display("FAIL stop_state: got %0d want IDLE", b_state); else passes++;
    checks++; if (got_b.size() != 12) $display("FAIL stop_count: got %0d beats want 12", got_b.size()); else passes++;
    for (int i = 0; i < 12 && i < got_b.size(); i++) begin
      checks++;
      if (got_b[i] !== exp_qb[i]) $display("FAIL stop_beat%0d: got %h want %h", i, got_b[i], exp_qb[i]);
      else passes++;
    end
    b_stop = 1'b0; b_cont = 1'b0; b_flag_in = 8'h00;
  endtask

  task automatic test_wide;
    int n = 0;
    for (int k = 0; k < 16; k++) begin
      c_word[k] = 16'hC000 + 16'(k);
      c_data[k*16 +: 16] = c_word[k];
    end
    exp_qc.delete(); got_c.delete();
    for (int g = 0; g < 8; g++) exp_qc.push_back({(g == 7), c_word[2*g+1], c_word[2*g]});
    c_if.tready = 1'b1; c_flag_in = 16'h0000; c_start = 1'b1;
    tick();
    c_start = 1'b0;
    tick();
    // Later groups become ready first and must wait for group 0.
    for (int g = 7; g >= 1; g--) begin
      c_flag_in[2*g +: 2] = 2'b11;
      tick(); tick();
    end
    checks++; if (c_if.tvalid !== 1'b0) $display("FAIL wide_held_off: got %b want 0", c_if.tvalid); else passes++;
    c_flag_in[1:0] = 2'b11;
    tick();
    while (c_busy && n < 40) begin tick(); n++; end
    checks++; if (c_busy !== 1'b0) $display("FAIL wide_idle_timeout: busy=%b want 0", c_busy); else passes++;
    checks++; if (got_c.size() != 8) $display("FAIL wide_count: got %0d beats want 8", got_c.size()); else passes++;
    for (int i = 0; i < 8 && i < got_c.size(); i++) begin
      checks++;
      if (got_c[i] !== exp_qc[i]) $display("FAIL wide_beat%0d: got %h want %h", i, got_c[i], exp_qc[i]);
      else passes++;
    end
    c_flag_in = 16'h0000;
  endtask

  task automatic test_reset_mid_send;
    int n = 0;
    set_a_words(32'hE000_0000);
    a_if.tready = 1'b0; a_flag_in = 8'hFF; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    while (!a_if.tvalid && n < 20) begin tick(); n++; end
    checks++; if (a_if.tvalid !== 1'b1) $display("FAIL mid_tvalid_timeout: got %b want 1", a_if.tvalid); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({a_if.tvalid, a_if.tlast} !== 2'b00) $display("FAIL mid_rst_ctrl: got v=%b l=%b want 0 0", a_if.tvalid, a_if.tlast); else passes++;
    checks++; if (a_if.tdata !== 128'h0) $display("FAIL mid_rst_tdata: got %h want 0", a_if.tdata); else passes++;
    checks++; if (a_flag_out !== 8'h00 || a_busy !== 1'b0) $display("FAIL mid_rst_flags: got flag=%h busy=%b want 00 0", a_flag_out, a_busy); else passes++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    set_a_words(32'hF000_0000);
    a_if.tready = 1'b1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_a_idle();
    compare_a("post_rst");
    a_flag_in = 8'h00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_stop_packet();
    test_wide();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
